// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // PS/2 frames use odd parity over the data byte plus the parity bit.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one PS/2 line.
// The output changes only after FILTER_LEN consecutive samples agree on the new level.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic line,
  output logic filtered
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // NOTE: state is updated with non-blocking assignments only, and reset is
  // sampled on the clock edge, so the flops infer without async reset pins.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      filtered <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line};
      if (sync_q[1] == filtered) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        filtered <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, then
// shifts out one byte on device-generated clock falls and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES    = 5760,
  parameter int FIRST_CLK_TIMEOUT = 720000,
  parameter int BIT_TIMEOUT       = 96000,
  parameter int FILTER_LEN        = 8
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAX_A     = (INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT;
  localparam int MAX_LIMIT = (MAX_A > FIRST_CLK_TIMEOUT) ? MAX_A : FIRST_CLK_TIMEOUT;
  localparam int CNT_W     = $clog2(MAX_LIMIT);

  // Clock is held low for INHIBIT_CYCLES in total; the final one of those is
  // the RTS cycle, where data is already pulled low.
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] FIRST_LAST   = CNT_W'(FIRST_CLK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BIT_TIMEOUT - 1);

  ps2_tx_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_limit;
  logic [2:0]       idx;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             clk_filt;
  logic             dat_filt;
  logic             clk_filt_q;
  logic             fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .line     (ps2_clk_i),
    .filtered (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .line     (ps2_dat_i),
    .filtered (dat_filt)
  );

  assign fall      = clk_filt_q & ~clk_filt;
  assign cnt_limit = (state == ST_DATA && idx == 3'd0) ? FIRST_LAST : BIT_LAST;
  assign tx_ready  = (state == ST_IDLE);
  assign busy      = ~tx_ready;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      clk_filt_q <= 1'b1;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      clk_filt_q <= clk_filt;
      // NOTE: default-low here makes tx_done/tx_error single-cycle pulses.
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            data_q     <= tx_data;
            parity_q   <= ps2_odd_parity(tx_data);
            ps2_clk_oe <= 1'b1;
            cnt        <= '0;
            state      <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            ps2_dat_oe <= 1'b1;
            state      <= ST_RTS;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RTS: begin
          ps2_clk_oe <= 1'b0;
          cnt        <= '0;
          idx        <= '0;
          state      <= ST_DATA;
        end

        ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAIT_IDLE: begin
          if (state == ST_WAIT_IDLE && clk_filt && dat_filt) begin
            tx_done <= 1'b1;
            cnt     <= '0;
            state   <= ST_IDLE;
          end else if (fall) begin
            cnt <= '0;
            case (state)
              ST_DATA: begin
                ps2_dat_oe <= ~data_q[idx];
                idx        <= idx + 3'd1;
                if (idx == 3'd7) state <= ST_PARITY;
              end
              ST_PARITY: begin
                ps2_dat_oe <= ~parity_q;
                state      <= ST_STOP;
              end
              ST_STOP: begin
                ps2_dat_oe <= 1'b0;
                state      <= ST_ACK;
              end
              ST_ACK: begin
                if (dat_filt) begin
                  tx_error <= 1'b1;
                  state    <= ST_IDLE;
                end else begin
                  state <= ST_WAIT_IDLE;
                end
              end
              default: ;
            endcase
          end else if (cnt == cnt_limit) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            cnt        <= '0;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device that
// generates the clock, captures the frame bit by bit and answers with an ACK.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 20;
  localparam int FIRST_TO = 200;
  localparam int BIT_TO = 100;
  localparam int FLEN = 4;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_i, ps2_dat_i;
  logic       dev_clk, dev_dat;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  // Open-drain wired-AND of host and device on each line.
  assign ps2_clk_i = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_i = ~ps2_dat_oe & dev_dat;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES    (INHIBIT),
    .FIRST_CLK_TIMEOUT (FIRST_TO),
    .BIT_TIMEOUT       (BIT_TO),
    .FILTER_LEN        (FLEN)
  ) dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_dat_i  (ps2_dat_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if ((tx_done && prev_done) || (tx_error && prev_err)) long_cnt++;
    prev_done = tx_done;
    prev_err  = tx_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Odd parity: the parity bit makes the count of ones across data+parity odd.
  function automatic logic exp_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2 == 0);
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check({tag, "_ready_wait"}, 32'(tx_ready), 32'd1);
  endtask

  // Offers a byte, keeps tx_valid high with other data while busy, and
  // measures how long the host holds the clock low.
  task automatic start_frame(input logic [7:0] b, input string tag);
    int n = 0;
    logic dat_last = 1'b0;
    wait_ready(tag);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_data = ~b;
    check({tag, "_ready_drop"}, 32'(tx_ready), 32'd0);
    while (ps2_clk_oe === 1'b1 && n < 1000) begin
      n++;
      dat_last = ps2_dat_oe;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check({tag, "_inhibit_len"}, 32'(n), 32'(INHIBIT));
    check({tag, "_start_before_release"}, 32'(dat_last), 32'd1);
  endtask

  task automatic device_clocks(input int nclk, input bit ack_ok, input int glitch_k,
                               input int h, output logic [10:1] bits);
    bits = '0;
    repeat (15) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk = 1'b0;
      repeat (h) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) bits[k] = ps2_dat_i;
      if (k == 10 && ack_ok) dev_dat = 1'b0;
      if (k == 11) dev_dat = 1'b1;
      if (k == glitch_k) begin
        repeat (3) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
      end
      repeat (h) @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack_ok, input int glitch_k,
                           input string tag);
    int d0, e0, n, h;
    logic [10:1] bits;
    h  = 12 + int'($urandom_range(6, 0));
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(b, tag);
    device_clocks(11, ack_ok, glitch_k, h, bits);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_data"}, 32'(bits[8:1]), 32'(b));
    check({tag, "_parity"}, 32'(bits[9]), 32'(exp_parity(b)));
    check({tag, "_stop"}, 32'(bits[10]), 32'd1);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), ack_ok ? 32'd1 : 32'd0);
    check({tag, "_error_pulses"}, 32'(err_cnt - e0), ack_ok ? 32'd0 : 32'd1);
    check({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] rb;
    logic [10:1] bits;
    int n, d0, e0;

    Reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    Reset_n = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(PS2_CMD_SET_LEDS, 1'b1, 0, "leds");
    run_frame(8'h00, 1'b1, 0, "b2b_00");
    run_frame(8'hFF, 1'b1, 0, "b2b_ff");
    run_frame(8'h01, 1'b1, 0, "b2b_01");
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      run_frame(rb, 1'b1, 0, "rand");
    end

    // Device never clocks after release.
    e0 = err_cnt;
    start_frame(8'($urandom), "timeout");
    n = 0;
    while (tx_error !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency_ok", 32'(n >= FIRST_TO && n <= FIRST_TO + 7), 32'd1);
    check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("timeout_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("timeout_error_pulses", 32'(err_cnt - e0), 32'd1);

    run_frame(8'($urandom), 1'b0, 0, "nack");
    run_frame(PS2_CMD_RESET, 1'b1, 0, "after_nack");
    run_frame(8'($urandom), 1'b1, 4, "glitch");

    // Reset pulse in the middle of the data bits.
    start_frame(8'($urandom), "midrst");
    device_clocks(3, 1'b0, 0, 14, bits);
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    Reset_n = 1'b0;
    @(negedge clk);
    check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("midrst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    Reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_no_error", 32'(err_cnt - e0), 32'd0);

    run_frame(PS2_CMD_ECHO, 1'b1, 0, "post_rst");

    check("pulses_never_together", 32'(both_cnt), 32'd0);
    check("pulses_single_cycle", 32'(long_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
